// File: rtl/time_set_ctrl.sv
// Front-panel run/set controller: debounced buttons, shadow hour/minute editing, commit load, blink mask.
// Latency: press pulse to mode/outputs one cycle; all outputs registered. Timer is frozen while editing.

module time_set_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic s1, s2;
  logic [CW-1:0] cnt;

  // Raw button is active-low; invert on entry so everything downstream is active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= ~raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= s2;
        press <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int BLINK_HALF      = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_adj,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       timer_en,
  output logic       load,
  output logic [5:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [5:0] blank_mask,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, COMMIT = 2'd3} state_t;

  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam int BW = $clog2(2 * BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_MID  = BW'(BLINK_HALF);

  state_t state;
  logic adj_lvl, p_adj, p_mode;
  logic [RW-1:0] rep_cnt;
  logic [BW-1:0] blink_cnt, blink_adv;
  logic [5:0] sh_h, sh_m, hours_cap, minutes_cap;
  logic editing, rep_tick, step, blank_on;

  time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(), .press(p_mode)
  );
  time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_adj (
    .clk(clk), .rst(rst), .raw(btn_adj), .level(adj_lvl), .press(p_adj)
  );

  always_comb begin
    editing     = (state == SET_H) || (state == SET_M);
    rep_tick    = editing && adj_lvl && (rep_cnt == REP_FIRE);
    step        = editing && (p_adj || rep_tick);
    blink_adv   = (step || blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    blank_on    = (blink_adv >= BLINK_MID);
    hours_cap   = (cur_hours > 6'd23) ? 6'd0 : cur_hours;
    minutes_cap = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
  end

  // A count of zero means idle; the press arms it at 1 so the first tick lands REPEAT_DELAY after it.
  always_ff @(posedge clk) begin
    if (rst || !adj_lvl || !editing) rep_cnt <= '0;
    else if (p_adj)                  rep_cnt <= RW'(1);
    else if (rep_tick)               rep_cnt <= REP_RELOAD;
    else if (rep_cnt != '0)          rep_cnt <= rep_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      mode         <= RUN;
      timer_en     <= 1'b1;
      load         <= 1'b0;
      load_hours   <= 6'd0;
      load_minutes <= 6'd0;
      load_seconds <= 6'd0;
      blank_mask   <= 6'd0;
      sh_h         <= 6'd0;
      sh_m         <= 6'd0;
      blink_cnt    <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: if (p_mode) begin
          sh_h       <= hours_cap;
          sh_m       <= minutes_cap;
          state      <= SET_H;
          mode       <= SET_H;
          timer_en   <= 1'b0;
          blink_cnt  <= '0;
          blank_mask <= 6'd0;
        end
        // A mode press in the same cycle as an adjust step discards the step.
        SET_H: if (p_mode) begin
          state      <= SET_M;
          mode       <= SET_M;
          blink_cnt  <= '0;
          blank_mask <= 6'd0;
        end else begin
          if (step) sh_h <= (sh_h == 6'd23) ? 6'd0 : sh_h + 6'd1;
          blink_cnt  <= blink_adv;
          blank_mask <= blank_on ? 6'b110000 : 6'b000000;
        end
        SET_M: if (p_mode) begin
          state        <= COMMIT;
          mode         <= COMMIT;
          load         <= 1'b1;
          load_hours   <= sh_h;
          load_minutes <= sh_m;
          load_seconds <= 6'd0;
          blink_cnt    <= '0;
          blank_mask   <= 6'd0;
        end else begin
          if (step) sh_m <= (sh_m == 6'd59) ? 6'd0 : sh_m + 6'd1;
          blink_cnt  <= blink_adv;
          blank_mask <= blank_on ? 6'b001100 : 6'b000000;
        end
        default: begin
          state    <= RUN;
          mode     <= RUN;
          timer_en <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel controller for the six-digit clock display: it debounces the two board pushbuttons and runs the run/set mode state machine. While the user edits, it freezes the timekeeping counter and holds shadow hours/minutes. On exit it issues a single-cycle load of the edited time into the counter. It also drives a per-digit blanking mask so the field being edited blinks on the multiplexed display.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required before a button level is accepted.
- `REPEAT_DELAY`, default 25000000: cycles an adjust press must be held before auto-repeat starts.
- `REPEAT_RATE`, default 5000000: cycles between auto-repeat steps.
- `BLINK_HALF`, default 12500000: cycles per blink half-period (visible, then blanked).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_mode` in 1: raw mode button, active-low, asynchronous to `clk`.
- `btn_adj` in 1: raw adjust button, active-low, asynchronous to `clk`.
- `cur_hours` in 6: live hours from the timer, 0–23.
- `cur_minutes` in 6: live minutes from the timer, 0–59.
- `timer_en` out 1: count enable to the timer; 1 = running.
- `load` out 1: one-cycle strobe; the timer takes `load_*` values.
- `load_hours` out 6: hours to load.
- `load_minutes` out 6: minutes to load.
- `load_seconds` out 6: always 0.
- `blank_mask` out 6: 1 = blank the digit. Bit0 = seconds units, bit1 = seconds tens, bit2 = minutes units, bit3 = minutes tens, bit4 = hours units, bit5 = hours tens.
- `mode` out 2: 0 = RUN, 1 = SET_H, 2 = SET_M, 3 = COMMIT.

## Operation
- **Button conditioning**
  - Each button passes through a 2-FF synchronizer and is then inverted to active-high.
  - A debounce counter runs while the synchronized level differs from the accepted level. It clears on any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the accepted level takes the new value.
  - A press pulse (`p_mode`, `p_adj`) is high for the first cycle the accepted level is 1.
- **FSM**, states as encoded on `mode`:
  - RUN: `timer_en`=1 and `blank_mask`=0. On `p_mode`, copy `cur_hours`/`cur_minutes` into the shadow registers `sh_h`/`sh_m` and go to SET_H.
  - SET_H: `timer_en`=0. On an adjust step, `sh_h` ← (`sh_h`==23) ? 0 : `sh_h`+1. On `p_mode`, go to SET_M.
  - SET_M: `timer_en`=0. On an adjust step, `sh_m` ← (`sh_m`==59) ? 0 : `sh_m`+1. On `p_mode`, go to COMMIT.
  - COMMIT: lasts one cycle. `load`=1, `load_hours`=`sh_h`, `load_minutes`=`sh_m`, `load_seconds`=0, `timer_en`=0. Then go to RUN unconditionally.
- **Adjust step** = `p_adj`, or an auto-repeat tick.
  - The auto-repeat counter starts at `p_adj` and clears whenever accepted adj = 0 or the state is RUN/COMMIT.
  - The first tick comes `REPEAT_DELAY` cycles after `p_adj`, then one tick every `REPEAT_RATE` cycles while held.
  - Adjust in RUN or COMMIT is ignored.
- **Simultaneous events:** `p_mode` and an adjust step in the same cycle → the mode transition wins, the adjust is discarded, and the shadow value is unchanged.
- **Blink**
  - The blink counter clears on entry to SET_H/SET_M and on every adjust step.
  - Phase is visible for cycles 0..`BLINK_HALF`-1 and blanked for `BLINK_HALF`..2·`BLINK_HALF`-1, then it wraps.
  - In the blanked phase, SET_H sets mask bits 5:4 and SET_M sets bits 3:2. All other bits are always 0.
- **Out-of-range capture:** if captured `cur_hours` > 23 or `cur_minutes` > 59, the shadow value is forced to 0 at capture.

## Timing
- All outputs are registered.
- Reset values:
  - state RUN, `mode`=0, `timer_en`=1, `load`=0
  - `load_hours`/`load_minutes`/`load_seconds`=0, `blank_mask`=0
  - accepted button levels = released (0), all counters = 0
- **Debounce latency:** after a clean raw edge, the accepted level changes exactly `DEBOUNCE_CYCLES`+2 cycles later. The press pulse is high in that same cycle.
- **Pulse to outputs:** a press pulse in cycle N produces the state change and the new `mode`/`timer_en`/`blank_mask` in cycle N+1. The RUN→SET_H capture uses the `cur_*` values sampled in cycle N.
- **`load`:**
  - high for exactly one cycle per commit;
  - `load_*` are valid in that cycle and hold their values afterwards;
  - `timer_en` returns to 1 in the cycle after `load`.
- **Glitches:** raw glitches shorter than `DEBOUNCE_CYCLES` cycles produce no pulse.
- **Release:** a release never produces a pulse.
- **Reset mid-edit:** state returns to RUN with no `load`; shadow edits are discarded; the timer resumes with its held value.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=5, `BLINK_HALF`=8.

- **Reset:** assert `rst` for 3 cycles → `mode`=0, `timer_en`=1, `load`=0, `blank_mask`=0.
- **Debounce:** `btn_mode` low for 3 cycles then high → no mode change. Held low instead → `mode`=1 exactly 7 cycles after the falling edge (pulse at +6).
- **Full edit:**
  - Setup: `cur_hours`=23, `cur_minutes`=59.
  - Stimulus: mode press, one adj press, mode press, one adj press, mode press.
  - Expected: `sh_h`=0, `sh_m`=0; a single `load` cycle with 0/0/0; `timer_en`=1 on the next cycle.
- **Auto-repeat:** in SET_M with `sh_m`=57, hold adj for 40 cycles after the pulse → steps at the pulse, then +20, +25, +30, +35 → `sh_m` reads 58, 59, 0, 1, 2.
- **Blink:**
  - In SET_H, idle → `blank_mask`=000000 for 8 cycles, then 110000 for 8 cycles, repeating.
  - An adj step in the blanked phase returns the mask to 000000 the next cycle.
- **Collision and reset:**
  - Mode and adj accepted in the same cycle in SET_H → `mode`=2 with `sh_h` unchanged.
  - `rst` in SET_M → `mode`=0, no `load` pulse ever seen.
